uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, divisor helper and configuration checks.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic bit cfg_ok(
    input int data_bits,
    input int stop_bits,
    input int div
  );
    return data_bits >= 5 && data_bits <= 9 &&
           (stop_bits == 1 || stop_bits == 2) &&
           div >= 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO, power-of-two depth.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = count == FULL_CNT;
  assign empty = count == '0;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter; define UART_TX_CTS_EN to add
// the cts_n_i flow-control input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 50_000_000,
  parameter int      BAUD       = 115200,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_i,
  input  logic                          wr_en_i,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n_i,
`endif
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic                          tx_o
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int CNTW = $clog2(DIV);
  localparam int BW   = $clog2(DATA_BITS);

  if (!cfg_ok(DATA_BITS, STOP_BITS, DIV)) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal DATA_BITS/STOP_BITS/DIV");
  end

  tx_state_e            state;
  logic [CNTW-1:0]      baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic                 cts_ok;
  logic                 wrap;
  logic                 stop_last;
  logic                 frame_end;
  logic                 pop;
  logic                 line;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en_i),
    .rd_en (pop),
    .wdata (data_i),
    .rdata (head),
    .full  (full_o),
    .empty (empty_o),
    .count (count_o)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Resets to "blocked" so nothing starts before cts_n is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cts_sync <= 2'b11;
    else      cts_sync <= {cts_sync[0], cts_n_i};
  end

  assign cts_ok = !cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign wrap      = baud_cnt == CNTW'(DIV - 1);
  assign stop_last = stop_idx == 1'(STOP_BITS - 1);
  assign frame_end = (state == ST_STOP) && wrap && stop_last;
  assign pop       = !empty_o && cts_ok &&
                     ((state == ST_IDLE) || frame_end);
  assign busy_o    = state != ST_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      baud_cnt <= (wrap || state == ST_IDLE) ? '0 : baud_cnt + CNTW'(1);
      if (pop) begin
        state    <= ST_START;
        baud_cnt <= '0;
        shreg    <= head;
        par_bit  <= (^head) ^ (PARITY == PARITY_ODD);
      end else if (wrap) begin
        unique case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
          ST_DATA: begin
            shreg    <= shreg >> 1;
            bit_idx  <= bit_idx + BW'(1);
            stop_idx <= 1'b0;
            if (bit_idx == BW'(DATA_BITS - 1))
              state <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end
          ST_PARITY: begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
          end
          ST_STOP: begin
            if (stop_last) state <= ST_IDLE;
            else           stop_idx <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    line = 1'b1;
    unique case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shreg[0];
      ST_PARITY: line = par_bit;
      default:   line = 1'b1;
    endcase
  end

  // The pin lags the FSM by one cycle so it always comes from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_o       <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      tx_o       <= line;
      overflow_o <= wr_en_i && full_o;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: 8N1, 7E2 and 7O2 instances at DIV=10, depth 4.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din;
  logic [2:0] wr;
  logic [2:0] full, empty, busy, ovf, tx;
  logic [8:0] cnt_p;
  logic       cts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .data_i(din[7:0]), .wr_en_i(wr[0]),
`ifdef UART_TX_CTS_EN
    .cts_n_i(cts),
`endif
    .full_o(full[0]), .empty_o(empty[0]), .count_o(cnt_p[2:0]),
    .busy_o(busy[0]), .overflow_o(ovf[0]), .tx_o(tx[0])
  );

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(PARITY_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_e (
    .clk(clk), .rst(rst), .data_i(din[6:0]), .wr_en_i(wr[1]),
`ifdef UART_TX_CTS_EN
    .cts_n_i(1'b0),
`endif
    .full_o(full[1]), .empty_o(empty[1]), .count_o(cnt_p[5:3]),
    .busy_o(busy[1]), .overflow_o(ovf[1]), .tx_o(tx[1])
  );

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(PARITY_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_o (
    .clk(clk), .rst(rst), .data_i(din[6:0]), .wr_en_i(wr[2]),
`ifdef UART_TX_CTS_EN
    .cts_n_i(1'b0),
`endif
    .full_o(full[2]), .empty_o(empty[2]), .count_o(cnt_p[8:6]),
    .busy_o(busy[2]), .overflow_o(ovf[2]), .tx_o(tx[2])
  );

  typedef struct {
    int         sel;
    logic [8:0] data;
    int         nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vec [7];

  logic [8:0]  bw [6];
  logic [11:0] bf [6];
  int          bc [6];
  logic        bfull [6];
  logic        bovf [6];

  function automatic logic [2:0] cnt_of(input int sel);
    return cnt_p[sel*3 +: 3];
  endfunction

  function automatic logic [11:0] f8n1(input logic [8:0] d);
    return {3'b001, d[7:0], 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Starts at the negedge one cycle before the start bit leaves.
  task automatic chk_frame(input int sel, input logic [11:0] f,
                           input int nbits, input bit last,
                           input string nm);
    for (int c = 0; c < nbits * 10; c++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d", nm, c / 10), 32'(tx[sel]),
          32'(f[c/10]));
      if (last && c == nbits * 10 - 2)
        chk({nm, " busy_end"}, 32'(busy[sel]), 32'd1);
      if (last && c == nbits * 10 - 1)
        chk({nm, " idle"}, 32'(busy[sel]), 32'd0);
    end
  endtask

  task automatic run_burst(input int sel, input int n, input int nf,
                           input int nbits, input string nm);
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          din = bw[k];
          wr[sel] = 1'b1;
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("%s cnt%0d", nm, k), 32'(cnt_of(sel)),
              32'(bc[k]));
          chk($sformatf("%s full%0d", nm, k), 32'(full[sel]),
              32'(bfull[k]));
          chk($sformatf("%s ovf%0d", nm, k), 32'(ovf[sel]),
              32'(bovf[k]));
        end
        wr[sel] = 1'b0;
        @(negedge clk);
        chk({nm, " ovf_end"}, 32'(ovf[sel]), 32'd0);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk({nm, " pre_start"}, 32'(tx[sel]), 32'd1);
        for (int k = 0; k < nf; k++)
          chk_frame(sel, bf[k], nbits, k == nf - 1,
                    $sformatf("%s f%0d", nm, k));
      end
    join
    @(negedge clk);
    chk({nm, " tx_idle"}, 32'(tx[sel]), 32'd1);
    chk({nm, " empty"}, 32'(empty[sel]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;

    vec[0] = '{0, 9'h045, 10, 12'h28A};
    vec[1] = '{1, 9'h003, 11, 12'h606};
    vec[2] = '{2, 9'h003, 11, 12'h706};
    vec[3] = '{0, 9'h0FF, 10, 12'h3FE};
    vec[4] = '{0, 9'h000, 10, 12'h200};
    vec[5] = '{1, 9'h055, 11, 12'h6AA};
    vec[6] = '{2, 9'h07F, 11, 12'h6FE};

    rst = 1'b0;
    din = '0;
    wr  = '0;
    cts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst tx%0d", s), 32'(tx[s]), 32'd1);
      chk($sformatf("rst busy%0d", s), 32'(busy[s]), 32'd0);
      chk($sformatf("rst full%0d", s), 32'(full[s]), 32'd0);
      chk($sformatf("rst empty%0d", s), 32'(empty[s]), 32'd1);
      chk($sformatf("rst cnt%0d", s), 32'(cnt_of(s)), 32'd0);
      chk($sformatf("rst ovf%0d", s), 32'(ovf[s]), 32'd0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      din = vec[i].data;
      wr[vec[i].sel] = 1'b1;
      @(posedge clk);
      #1;
      wr = '0;
      @(negedge clk);
      chk($sformatf("v%0d cnt", i), 32'(cnt_of(vec[i].sel)), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d lat", i), 32'(tx[vec[i].sel]), 32'd1);
      chk($sformatf("v%0d busy", i), 32'(busy[vec[i].sel]), 32'd1);
      chk_frame(vec[i].sel, vec[i].frame, vec[i].nbits, 1'b1,
                $sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d tx_end", i), 32'(tx[vec[i].sel]), 32'd1);
      chk($sformatf("v%0d empty", i), 32'(empty[vec[i].sel]), 32'd1);
    end

    // Six writes into a depth-4 FIFO; the first is popped at E+1.
    bw    = '{9'h045, 9'h0FF, 9'h000, 9'h0A5, 9'h03C, 9'h099};
    bc    = '{1, 1, 2, 3, 4, 4};
    bfull = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) bf[k] = f8n1(bw[k]);
    run_burst(0, 6, 5, 10, "burst");

    // Push lands in the same cycle the FSM pops the only word.
    bw[0] = 9'h003;
    bw[1] = 9'h055;
    bc[0] = 1;
    bc[1] = 1;
    bfull[0] = 1'b0;
    bfull[1] = 1'b0;
    bovf[0] = 1'b0;
    bovf[1] = 1'b0;
    bf[0] = 12'h706;
    bf[1] = 12'h7AA;
    run_burst(2, 2, 2, 11, "pushpop");

    @(posedge clk);
    #1;
    din = 9'h000;
    wr[0] = 1'b1;
    @(posedge clk);
    #1;
    din = 9'h011;
    @(posedge clk);
    #1;
    din = 9'h022;
    @(posedge clk);
    #1;
    wr = '0;
    repeat (35) @(posedge clk);
    #1;
    chk("mid tx_low", 32'(tx[0]), 32'd0);
    chk("mid busy", 32'(busy[0]), 32'd1);
    chk("mid cnt", 32'(cnt_of(0)), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst tx", 32'(tx[0]), 32'd1);
    chk("arst cnt", 32'(cnt_of(0)), 32'd0);
    chk("arst empty", 32'(empty[0]), 32'd1);
    chk("arst busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("no_resend", 32'(bad), 32'd0);

`ifdef UART_TX_CTS_EN
    cts = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din = 9'h055;
    wr[0] = 1'b1;
    @(posedge clk);
    #1;
    wr = '0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("cts hold", 32'(bad), 32'd0);
    chk("cts hold cnt", 32'(cnt_of(0)), 32'd1);
    @(posedge clk);
    #1;
    cts = 1'b0;
    fork
      begin
        repeat (4) @(negedge clk);
        chk("cts lat", 32'(tx[0]), 32'd1);
        chk_frame(0, 12'h2AA, 10, 1'b1, "cts_a");
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        din = 9'h00F;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        wr = '0;
        repeat (20) @(posedge clk);
        #1;
        cts = 1'b1;
      end
    join
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
    end
    chk("cts block", 32'(bad), 32'd0);
    chk("cts block cnt", 32'(cnt_of(0)), 32'd1);
    @(posedge clk);
    #1;
    cts = 1'b0;
    repeat (4) @(negedge clk);
    chk("cts lat2", 32'(tx[0]), 32'd1);
    chk_frame(0, 12'h21E, 10, 1'b1, "cts_b");
    @(negedge clk);
    chk("cts end", 32'(tx[0]), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
